// File: rtl/valve_sequencer.sv
// valve_sequencer: actuator stage driving four zone valves and the pump, with
// staggered opening, minimum/maximum valve on-time and a fault/lockout sequence.
module valve_sequencer #(
  parameter int STAGGER_CYC = 4,
  parameter int MIN_ON_CYC  = 8,
  parameter int MAX_ON_CYC  = 1000,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] R1,
  input  logic [1:0] R2,
  input  logic [1:0] E,
  output logic [3:0] V,
  output logic       pump,
  output logic       alarm,
  output logic [3:0] to_flag
);

  localparam int TW = $clog2(MAX_ON_CYC + 1);
  localparam int SW = $clog2(STAGGER_CYC + 1);
  localparam int LW = $clog2(LOCKOUT_CYC + 1);

  localparam logic [TW-1:0] MIN_T       = TW'(MIN_ON_CYC);
  localparam logic [TW-1:0] MAX_T       = TW'(MAX_ON_CYC);
  localparam logic [TW-1:0] TIMER_ZERO  = TW'(0);
  localparam logic [TW-1:0] TIMER_ONE   = TW'(1);
  localparam logic [TW-1:0] TIMER_FULL  = {TW{1'b1}};
  localparam logic [SW-1:0] STAG_RELOAD = SW'(STAGGER_CYC - 1);
  localparam logic [SW-1:0] STAG_ZERO   = SW'(0);
  localparam logic [SW-1:0] STAG_ONE    = SW'(1);
  localparam logic [LW-1:0] LOCK_RELOAD = LW'(LOCKOUT_CYC - 1);
  localparam logic [LW-1:0] LOCK_ZERO   = LW'(0);
  localparam logic [LW-1:0] LOCK_ONE    = LW'(1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_RUN     = 3'd2,
    S_FAULT   = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    v_q, v_d;
  logic [3:0]    to_flag_q, to_flag_d;
  logic          pump_q, pump_d;
  logic          alarm_q, alarm_d;
  logic [SW-1:0] stag_q, stag_d;
  logic [LW-1:0] lock_q, lock_d;
  logic [TW-1:0] timer_q [4];
  logic [TW-1:0] timer_d [4];

  logic [3:0] req_s, elig_s, cand_s, close_s, tmo_s;
  logic       flt_s;

  function automatic logic [TW-1:0] sat_inc(input logic [TW-1:0] t);
    logic [TW-1:0] r;
    if (t == TIMER_FULL) r = t;
    else                 r = t + TIMER_ONE;
    return r;
  endfunction

  function automatic logic [3:0] pick_highest(input logic [3:0] m);
    logic [3:0] r;
    if      (m[3]) r = 4'b1000;
    else if (m[2]) r = 4'b0100;
    else if (m[1]) r = 4'b0010;
    else if (m[0]) r = 4'b0001;
    else           r = 4'b0000;
    return r;
  endfunction

  assign req_s  = {R1, R2};
  assign flt_s  = (E != 2'b01);
  assign elig_s = req_s & ~to_flag_q;
  assign cand_s = pick_highest(req_s & ~v_q & ~to_flag_q);

  // Per-valve close decisions: timeout closes unconditionally, a dropped request only after min-on.
  always_comb begin
    close_s = 4'b0000;
    tmo_s   = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tmo_s[i]   = v_q[i] && (timer_q[i] >= MAX_T);
      close_s[i] = tmo_s[i] || (v_q[i] && !req_s[i] && (timer_q[i] >= MIN_T));
    end
  end

  // Next-state and output logic; a fault overrides every state.
  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    pump_d    = pump_q;
    alarm_d   = alarm_q;
    to_flag_d = to_flag_q & req_s;
    stag_d    = stag_q;
    lock_d    = lock_q;
    if (flt_s) begin
      state_d   = S_FAULT;
      v_d       = 4'b0000;
      pump_d    = 1'b0;
      alarm_d   = 1'b1;
      to_flag_d = 4'b0000;
      stag_d    = STAG_ZERO;
      lock_d    = LOCK_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          v_d     = 4'b0000;
          alarm_d = 1'b0;
          if (elig_s != 4'b0000) begin
            state_d = S_START;
            pump_d  = 1'b1;
            stag_d  = STAG_RELOAD;
          end else begin
            pump_d  = 1'b0;
          end
        end
        S_START: begin
          v_d     = 4'b0000;
          pump_d  = 1'b1;
          alarm_d = 1'b0;
          if (elig_s == 4'b0000) begin
            state_d = S_IDLE;
            pump_d  = 1'b0;
            stag_d  = STAG_ZERO;
          end else if (stag_q == STAG_ZERO) begin
            // First valve opens on the same edge the stagger interval expires.
            state_d = S_RUN;
            v_d     = cand_s;
            stag_d  = STAG_RELOAD;
          end else begin
            stag_d  = stag_q - STAG_ONE;
          end
        end
        S_RUN: begin
          pump_d    = 1'b1;
          alarm_d   = 1'b0;
          to_flag_d = (to_flag_q | tmo_s) & req_s;
          if ((stag_q == STAG_ZERO) && (cand_s != 4'b0000)) begin
            v_d    = (v_q & ~close_s) | cand_s;
            stag_d = STAG_RELOAD;
          end else if (stag_q != STAG_ZERO) begin
            v_d    = v_q & ~close_s;
            stag_d = stag_q - STAG_ONE;
          end else begin
            v_d    = v_q & ~close_s;
          end
          if ((v_d == 4'b0000) && ((req_s & ~to_flag_d) == 4'b0000)) begin
            state_d = S_IDLE;
            pump_d  = 1'b0;
            stag_d  = STAG_ZERO;
          end else begin
            state_d = S_RUN;
          end
        end
        S_FAULT: begin
          state_d   = S_LOCKOUT;
          v_d       = 4'b0000;
          pump_d    = 1'b0;
          alarm_d   = 1'b1;
          to_flag_d = 4'b0000;
          lock_d    = LOCK_RELOAD;
        end
        S_LOCKOUT: begin
          v_d       = 4'b0000;
          pump_d    = 1'b0;
          to_flag_d = 4'b0000;
          if (lock_q == LOCK_ZERO) begin
            state_d = S_IDLE;
            alarm_d = 1'b0;
          end else begin
            alarm_d = 1'b1;
            lock_d  = lock_q - LOCK_ONE;
          end
        end
        default: begin
          state_d   = S_IDLE;
          v_d       = 4'b0000;
          pump_d    = 1'b0;
          alarm_d   = 1'b0;
          to_flag_d = 4'b0000;
          stag_d    = STAG_ZERO;
          lock_d    = LOCK_ZERO;
        end
      endcase
    end
  end

  // On-timers count the cycles a valve has been open, including the current one.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      timer_d[i] = v_d[i] ? sat_inc(timer_q[i]) : TIMER_ZERO;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      v_q       <= 4'b0000;
      pump_q    <= 1'b0;
      alarm_q   <= 1'b0;
      to_flag_q <= 4'b0000;
      stag_q    <= STAG_ZERO;
      lock_q    <= LOCK_ZERO;
      for (int i = 0; i < 4; i++) timer_q[i] <= TIMER_ZERO;
    end else begin
      state_q   <= state_d;
      v_q       <= v_d;
      pump_q    <= pump_d;
      alarm_q   <= alarm_d;
      to_flag_q <= to_flag_d;
      stag_q    <= stag_d;
      lock_q    <= lock_d;
      for (int i = 0; i < 4; i++) timer_q[i] <= timer_d[i];
    end
  end

  assign V       = v_q;
  assign pump    = pump_q;
  assign alarm   = alarm_q;
  assign to_flag = to_flag_q;

endmodule

// File: tb/tb_valve_sequencer.sv
// Testbench for valve_sequencer: directed vector table, hand-written corner
// sequences, then random stimulus checked against a timestamp-based model.
module tb_valve_sequencer;

  localparam int STAG  = 4;
  localparam int MINON = 8;
  localparam int MAXON = 20;
  localparam int LOCK  = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] R1, R2, E;
  logic [3:0] V, to_flag;
  logic       pump, alarm;

  int tests_run    = 0;
  int tests_failed = 0;
  bit use_model    = 1'b0;

  always #5 clk = ~clk;

  valve_sequencer #(
    .STAGGER_CYC(STAG), .MIN_ON_CYC(MINON), .MAX_ON_CYC(MAXON), .LOCKOUT_CYC(LOCK)
  ) dut (
    .clk(clk), .reset(reset), .R1(R1), .R2(R2), .E(E),
    .V(V), .pump(pump), .alarm(alarm), .to_flag(to_flag)
  );

  // Reference model: absolute edge numbers for pump start, valve opening and lockout end.
  int       n_edge = 0;
  bit       m_fault;
  int       lock_until;
  bit       m_pump;
  int       next_ok;
  int       open_at [4];
  bit [3:0] m_tof;

  task automatic model_clear();
    m_fault = 1'b0; lock_until = -1; m_pump = 1'b0; next_ok = 0; m_tof = 4'b0000;
    for (int i = 0; i < 4; i++) open_at[i] = -1;
  endtask

  task automatic model_edge(input bit rst, input logic [3:0] req, input logic [1:0] e);
    int pick;
    int age;
    bit any_open;
    n_edge++;
    if (rst) begin
      model_clear();
    end else if (e != 2'b01) begin
      model_clear();
      m_fault = 1'b1;
    end else if (m_fault) begin
      m_fault = 1'b0;
      lock_until = n_edge + LOCK;
    end else if (lock_until >= 0) begin
      if (n_edge >= lock_until) lock_until = -1;
    end else if (!m_pump) begin
      m_tof = m_tof & req;
      if ((req & ~m_tof) != 4'b0000) begin
        m_pump = 1'b1;
        next_ok = n_edge + STAG;
      end
    end else begin
      pick = -1;
      for (int i = 3; i >= 0; i--)
        if (pick < 0 && req[i] && open_at[i] < 0 && !m_tof[i]) pick = i;
      for (int i = 0; i < 4; i++) begin
        if (open_at[i] >= 0) begin
          age = n_edge - open_at[i];
          if (age >= MAXON) begin
            open_at[i] = -1;
            if (req[i]) m_tof[i] = 1'b1;
          end else if (!req[i] && age >= MINON) begin
            open_at[i] = -1;
          end
        end
      end
      m_tof = m_tof & req;
      if (pick >= 0 && n_edge >= next_ok) begin
        open_at[pick] = n_edge;
        next_ok = n_edge + STAG;
      end
      any_open = 1'b0;
      for (int i = 0; i < 4; i++) if (open_at[i] >= 0) any_open = 1'b1;
      if (!any_open && (req & ~m_tof) == 4'b0000) m_pump = 1'b0;
    end
  endtask

  function automatic logic [3:0] model_v();
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (open_at[i] >= 0);
    return r;
  endfunction

  task automatic check(input string name, input logic [3:0] ev, input logic ep,
                       input logic ea, input logic [3:0] et);
    tests_run++;
    if (V !== ev || pump !== ep || alarm !== ea || to_flag !== et) begin
      tests_failed++;
      $display("FAIL %s @%0t: got V=%b pump=%b alarm=%b to_flag=%b, expected V=%b pump=%b alarm=%b to_flag=%b",
               name, $time, V, pump, alarm, to_flag, ev, ep, ea, et);
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      model_edge(reset, {R1, R2}, E);
      #1;
      if (use_model) check("model", model_v(), m_pump, m_fault || (lock_until >= 0), m_tof);
    end
  endtask

  typedef struct {
    int         cyc;
    logic       rst;
    logic [1:0] r1, r2, e;
    logic [3:0] v;
    logic       p, a;
    logic [3:0] t;
  } vec_t;

  vec_t tbl [$];

  initial begin
    reset = 1'b1; R1 = 2'b00; R2 = 2'b00; E = 2'b01;
    model_clear();

    // reset, single zone with min-on close, four-way stagger and staggered closing
    tbl.push_back('{2, 1'b1, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b10, 2'b00, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{3, 1'b0, 2'b10, 2'b00, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b10, 2'b00, 2'b01, 4'b1000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{2, 1'b0, 2'b10, 2'b00, 2'b01, 4'b1000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{5, 1'b0, 2'b00, 2'b00, 2'b01, 4'b1000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{3, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b11, 2'b11, 2'b01, 4'b0000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{4, 1'b0, 2'b11, 2'b11, 2'b01, 4'b1000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{3, 1'b0, 2'b11, 2'b11, 2'b01, 4'b1000, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b11, 2'b11, 2'b01, 4'b1100, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{4, 1'b0, 2'b11, 2'b11, 2'b01, 4'b1110, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{3, 1'b0, 2'b11, 2'b11, 2'b01, 4'b1110, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b11, 2'b11, 2'b01, 4'b1111, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0011, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{2, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0011, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0001, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{3, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0001, 1'b1, 1'b0, 4'b0000});
    tbl.push_back('{1, 1'b0, 2'b00, 2'b00, 2'b01, 4'b0000, 1'b0, 1'b0, 4'b0000});

    for (int i = 0; i < tbl.size(); i++) begin
      reset = tbl[i].rst; R1 = tbl[i].r1; R2 = tbl[i].r2; E = tbl[i].e;
      step(tbl[i].cyc);
      check($sformatf("vec%0d", i), tbl[i].v, tbl[i].p, tbl[i].a, tbl[i].t);
    end

    // timeout: close after MAX_ON, no reopen while held, flag clears on drop
    R2 = 2'b01;
    step(1);  check("to_pump",     4'b0000, 1'b1, 1'b0, 4'b0000);
    step(4);  check("to_open",     4'b0001, 1'b1, 1'b0, 4'b0000);
    step(19); check("to_last_on",  4'b0001, 1'b1, 1'b0, 4'b0000);
    step(1);  check("to_close",    4'b0000, 1'b0, 1'b0, 4'b0001);
    step(10); check("to_noreopen", 4'b0000, 1'b0, 1'b0, 4'b0001);
    R2 = 2'b00;
    step(1);  check("to_clear",    4'b0000, 1'b0, 1'b0, 4'b0000);
    R2 = 2'b01;
    step(1);  check("to_re_pump",  4'b0000, 1'b1, 1'b0, 4'b0000);
    step(4);  check("to_re_open",  4'b0001, 1'b1, 1'b0, 4'b0000);
    R2 = 2'b00;
    step(12); check("to_re_close", 4'b0000, 1'b0, 1'b0, 4'b0000);

    // fault while two valves open, then lockout and restart
    R1 = 2'b11;
    step(5);  check("flt_v1",      4'b1000, 1'b1, 1'b0, 4'b0000);
    step(4);  check("flt_v2",      4'b1100, 1'b1, 1'b0, 4'b0000);
    E = 2'b00;
    step(1);  check("flt_trip",    4'b0000, 1'b0, 1'b1, 4'b0000);
    step(2);  check("flt_hold",    4'b0000, 1'b0, 1'b1, 4'b0000);
    E = 2'b01;
    step(16); check("lock_end",    4'b0000, 1'b0, 1'b1, 4'b0000);
    step(1);  check("lock_idle",   4'b0000, 1'b0, 1'b0, 4'b0000);
    step(1);  check("lock_start",  4'b0000, 1'b1, 1'b0, 4'b0000);
    step(4);  check("lock_reopen", 4'b1000, 1'b1, 1'b0, 4'b0000);
    E = 2'b00;
    step(1);  check("rl_trip",     4'b0000, 1'b0, 1'b1, 4'b0000);
    E = 2'b01;
    step(10); check("rl_mid",      4'b0000, 1'b0, 1'b1, 4'b0000);
    E = 2'b00;
    step(1);  check("rl_refault",  4'b0000, 1'b0, 1'b1, 4'b0000);
    E = 2'b01;
    step(16); check("rl_restart",  4'b0000, 1'b0, 1'b1, 4'b0000);
    step(1);  check("rl_idle",     4'b0000, 1'b0, 1'b0, 4'b0000);

    // invalid E = 11 is a fault; reset in RUN clears everything at once
    step(5);  check("e11_open",    4'b1000, 1'b1, 1'b0, 4'b0000);
    E = 2'b11;
    step(1);  check("e11_trip",    4'b0000, 1'b0, 1'b1, 4'b0000);
    E = 2'b01;
    step(17); check("e11_idle",    4'b0000, 1'b0, 1'b0, 4'b0000);
    step(5);  check("rst_open",    4'b1000, 1'b1, 1'b0, 4'b0000);
    reset = 1'b1;
    step(1);  check("rst_run",     4'b0000, 1'b0, 1'b0, 4'b0000);
    reset = 1'b0; R1 = 2'b00;
    step(1);  check("rst_after",   4'b0000, 1'b0, 1'b0, 4'b0000);

    // random stimulus against the reference model
    reset = 1'b1;
    step(1);
    use_model = 1'b1;
    reset = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      for (int b = 0; b < 2; b++) begin
        if ($urandom_range(0, 39) == 0) R1[b] = ~R1[b];
        if ($urandom_range(0, 39) == 0) R2[b] = ~R2[b];
      end
      if (E == 2'b01) begin
        if ($urandom_range(0, 299) == 0) begin
          case ($urandom_range(0, 2))
            0:       E = 2'b00;
            1:       E = 2'b10;
            default: E = 2'b11;
          endcase
        end
      end else if ($urandom_range(0, 2) == 0) begin
        E = 2'b01;
      end
      reset = ($urandom_range(0, 999) == 0);
      step(1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
